// File: rtl/reg_file_mp_pkg.sv
// Shared constants and elaboration helpers for the multi-port register file.
package reg_file_mp_pkg;

    // MIPS register indices with a fixed role.
    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;
    localparam int REG_A0   = 4;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

    // Register id width for a given register count.
    function automatic int reg_file_addr_w(input int num_regs);
        return $clog2(num_regs);
    endfunction

    // Legal read-port counts are 1 to 4.
    function automatic bit reg_file_num_read_ok(input int num_read);
        return (num_read >= 1) && (num_read <= 4);
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode-stage bundle: read ports, writeback, link, scoreboard control and status.
interface reg_file_mp_if
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2
);
    localparam int ADDR_W = reg_file_addr_w(NUM_REGS);

    logic [NUM_READ*ADDR_W-1:0]     rd_id;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_value;
    logic [NUM_READ-1:0]            rd_busy;
    logic                           wr_en;
    logic [ADDR_W-1:0]              wr_id;
    logic [DATA_WIDTH-1:0]          wr_value;
    logic                           link_en;
    logic [DATA_WIDTH-1:0]          link_value;
    logic                           busy_set;
    logic [ADDR_W-1:0]              busy_set_id;
    logic                           flush;
    logic [NUM_REGS-1:0]            busy_vector;
    logic [DATA_WIDTH-1:0]          syscall_funct;
    logic [DATA_WIDTH-1:0]          syscall_param1;

    // Decode / writeback side.
    modport master (
        output rd_id, wr_en, wr_id, wr_value, link_en, link_value,
               busy_set, busy_set_id, flush,
        input  rd_value, rd_busy, busy_vector, syscall_funct, syscall_param1
    );

    // Register file side.
    modport slave (
        input  rd_id, wr_en, wr_id, wr_value, link_en, link_value,
               busy_set, busy_set_id, flush,
        output rd_value, rd_busy, busy_vector, syscall_funct, syscall_param1
    );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write busy bits: flush beats set, set beats commit-clear; register 0 never busy.
module reg_file_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                busy_set,
    input  logic [ADDR_W-1:0]   busy_set_id,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_id,
    input  logic                link_en,
    output logic [NUM_REGS-1:0] busy_vector
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;

    // Next-state per register following flush > set > commit-clear > hold.
    always_comb begin
        // NOTE: default assignment first so no path leaves busy_next unassigned (no latch).
        busy_next = busy_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (flush) begin
                busy_next[r] = 1'b0;
            end else if (busy_set && (busy_set_id == ADDR_W'(r))) begin
                busy_next[r] = 1'b1;
            end else if ((wr_en && (wr_id == ADDR_W'(r))) || (link_en && (r == LINK_REG))) begin
                busy_next[r] = 1'b0;
            end
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy_vector = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port MIPS register file with link port, optional write bypass and RAW scoreboard.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_READ   = 2,
    parameter int LINK_REG   = REG_RA,
    parameter int BYPASS     = 1
) (
    input logic          clock,
    input logic          reset_n,
    reg_file_mp_if.slave bus
);

    localparam int ADDR_W = reg_file_addr_w(NUM_REGS);
    localparam logic [ADDR_W-1:0] ZERO_ID = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] LINK_ID = ADDR_W'(LINK_REG);

    if (!reg_file_num_read_ok(NUM_READ)) begin : g_bad_num_read
        $error("reg_file_mp: NUM_READ must be 1 to 4");
    end

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_vec;

    // Register array: writeback then link, so link wins a collision on LINK_REG.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the array is reset on purpose; software relies on all registers reading 0 after reset.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (bus.wr_en && (bus.wr_id != ZERO_ID)) begin
                regs[bus.wr_id] <= bus.wr_value;
            end
            if (bus.link_en) begin
                regs[LINK_ID] <= bus.link_value;
            end
        end
    end

    reg_file_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .LINK_REG (LINK_REG)
    ) u_scoreboard (
        .clock       (clock),
        .reset_n     (reset_n),
        .busy_set    (bus.busy_set),
        .busy_set_id (bus.busy_set_id),
        .flush       (bus.flush),
        .wr_en       (bus.wr_en),
        .wr_id       (bus.wr_id),
        .link_en     (bus.link_en),
        .busy_vector (busy_vec)
    );

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_W-1:0]     id;
        logic [DATA_WIDTH-1:0] value;
        logic                  fwd;

        assign id = bus.rd_id[k*ADDR_W +: ADDR_W];

        // Read mux: stored value, optionally replaced by this cycle's commit (link over wr).
        always_comb begin
            value = regs[id];
            fwd   = 1'b0;
            if (BYPASS != 0) begin
                if (bus.link_en && (id == LINK_ID)) begin
                    value = bus.link_value;
                    fwd   = 1'b1;
                end else if (bus.wr_en && (id == bus.wr_id)) begin
                    value = bus.wr_value;
                    fwd   = 1'b1;
                end
            end
            if (id == ZERO_ID) begin
                value = '0;
                fwd   = 1'b0;
            end
        end

        assign bus.rd_value[k*DATA_WIDTH +: DATA_WIDTH] = value;
        // A forwarded commit satisfies the hazard unless a new producer is issued to the same id.
        assign bus.rd_busy[k] = busy_vec[id] &&
                                !(fwd && !(bus.busy_set && (bus.busy_set_id == id)));
    end

    assign bus.busy_vector    = busy_vec;
    assign bus.syscall_funct  = regs[REG_V0];
    assign bus.syscall_param1 = regs[REG_A0];

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the single-issue MIPS register file, used in the decode stage.
- Provides NUM_READ combinational read ports, one writeback port and a dedicated link ($ra) port.
- Writes land on the rising clock edge, with an optional same-cycle write-to-read bypass.
- Holds a per-register pending-write scoreboard (busy bits) so decode can detect RAW hazards. Also exports the syscall registers $v0 and $a0.

Parameters:
- DATA_WIDTH, 32, width of each register.
- NUM_REGS, 32, number of architectural registers; power of two, at least 8.
- ADDR_W, $clog2(NUM_REGS), register id width; derived, not overridden.
- NUM_READ, 2, number of read ports; range 1 to 4.
- LINK_REG, 31, index written by the link port.
- BYPASS, 1, 1 forwards same-cycle writes to the read ports; 0 returns stored values only.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_id  in  NUM_READ*ADDR_W  read register ids; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_value  out  NUM_READ*DATA_WIDTH  read data, combinational from rd_id.
- rd_busy  out  NUM_READ  1 when the register read on port k has a pending write.
- wr_en  in  1  writeback enable.
- wr_id  in  ADDR_W  writeback destination.
- wr_value  in  DATA_WIDTH  writeback data.
- link_en  in  1  link write enable (jal/jalr).
- link_value  in  DATA_WIDTH  return address.
- busy_set  in  1  issue marks busy_set_id as pending.
- busy_set_id  in  ADDR_W  destination being issued.
- flush  in  1  clears all busy bits (pipeline flush).
- busy_vector  out  NUM_REGS  raw scoreboard state.
- syscall_funct  out  DATA_WIDTH  stored value of register 2 ($v0).
- syscall_param1  out  DATA_WIDTH  stored value of register 4 ($a0).

Behaviour:
- Reset (async on reset_n low):
  - All registers are 0 and all busy bits are 0.
  - rd_value follows the zeroed array; rd_busy, busy_vector, syscall_funct and syscall_param1 are 0.
  - Reset asserted mid-cycle discards any in-flight write.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and busy_set targeting 0 are ignored.
- Write (rising edge):
  - If wr_en and wr_id != 0, then reg[wr_id] <= wr_value.
  - If link_en, then reg[LINK_REG] <= link_value.
  - If wr_en, wr_id == LINK_REG and link_en are all asserted, link_value wins.
- Read:
  - Purely combinational, zero latency.
  - With BYPASS=1, a port whose id matches an active write this cycle returns that write's value, using the same link-over-wr priority. Id 0 still returns 0.
  - With BYPASS=0, ports return the stored value; the new value is visible the cycle after the edge.
- Scoreboard (rising edge, evaluated per register r != 0, in this order):
  1. flush sets all busy bits to 0. Flush has priority over everything except reset, and busy_set in the same cycle is dropped.
  2. Otherwise, busy_set with busy_set_id == r sets busy[r] to 1. Set beats a same-cycle clear, because a new producer has been issued.
  3. Otherwise, a write commit to r (wr_en with wr_id == r, or link_en with r == LINK_REG) clears busy[r].
  4. Otherwise busy[r] holds.
- rd_busy[k]:
  - Equals busy[rd_id[k]].
  - With BYPASS=1, rd_busy[k] is forced to 0 when a same-cycle commit to that register is being forwarded and busy_set does not target that register this cycle.
  - Always 0 for id 0.
- Syscall outputs are the stored values of registers 2 and 4, never bypassed.
- Out-of-range ids cannot occur because NUM_REGS is a power of two.

Decomposition:
- Shared package/header holds: the register-index constants (zero, v0 = 2, a0 = 4, sp, ra = 31), ADDR_W derivation, and the NUM_READ range check.
- One natural sub-module: reg_file_scoreboard (the busy bits with set/clear/flush priority and the busy_vector output).
- The data array, write priority and the per-port bypass muxes are generated in the top module with a generate loop over NUM_READ.

Test Plan:
- Reset then read all ids on every port -> rd_value 0, rd_busy 0, busy_vector 0.
- wr_en=1, wr_id=5, wr_value=0xDEADBEEF, rd_id[0]=5 same cycle -> BYPASS=1: rd_value 0xDEADBEEF immediately. BYPASS=0: old value 0, then 0xDEADBEEF after the edge.
- wr_en=1, wr_id=31, wr_value=0x1111 together with link_en=1, link_value=0x00400020 -> reg31 = 0x00400020. Also wr_id=0, value 0x5 -> reads of id 0 stay 0.
- busy_set id 8 -> busy[8]=1. Next cycle wr_en id 8 together with busy_set id 8 -> busy stays 1. A later wr_en id 8 alone -> busy clears.
- Set busy on ids 3, 9 and 31, then flush=1 with busy_set id 12 -> busy_vector 0 after the edge.
- Write 10 to reg 2 and 0x10010000 to reg 4 -> syscall_funct 10 and syscall_param1 0x10010000 after the edge, not before. Then pulse reset_n low mid-cycle -> all outputs 0 asynchronously.
